// File: rtl/apb4_cmd_master_if.sv
// Bundles the command, APB4 and response signals of the APB4 command requester.
// The master modport is the requester's view and the slave modport is the
// environment's view.
interface apb4_cmd_master_if #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   // Command channel
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic [STRB_WIDTH-1:0] cmd_strb;

   // APB4 bus
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [STRB_WIDTH-1:0] pstrb;
   logic [2:0]            pprot;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   // Response channel
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_slverr;
   logic                  rsp_timeout;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
      input  prdata, pready, pslverr, rsp_ready,
      output cmd_ready, psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
      output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
      output prdata, pready, pslverr, rsp_ready,
      input  cmd_ready, psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
      input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout
   );
endinterface

// File: rtl/apb4_cmd_master.sv
// APB4 requester: turns one valid/ready command into an APB4 SETUP/ACCESS
// transfer, waits for pready (bounded by an optional wait-state timeout) and
// returns the result on a valid/ready response channel. Only one transfer is
// ever outstanding.
module apb4_cmd_master #(
   parameter int ADDR_WIDTH     = 3,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic               pclk,
   input logic               presetn,
   apb4_cmd_master_if.master bus
);
   localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   state_t               state;
   logic [CNT_WIDTH-1:0] wait_cnt;

   // Protection attributes are always normal, secure, data access.
   assign bus.pprot = 3'b000;

   // Transfer sequencer with every handshake and bus output registered alongside the state.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state           <= IDLE;
         wait_cnt        <= '0;
         bus.cmd_ready   <= 1'b1;
         bus.psel        <= 1'b0;
         bus.penable     <= 1'b0;
         bus.pwrite      <= 1'b0;
         bus.paddr       <= '0;
         bus.pwdata      <= '0;
         bus.pstrb       <= '0;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_rdata   <= '0;
         bus.rsp_slverr  <= 1'b0;
         bus.rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  bus.pwrite    <= bus.cmd_write;
                  bus.paddr     <= bus.cmd_addr;
                  bus.pwdata    <= bus.cmd_wdata;
                  bus.pstrb     <= bus.cmd_write ? bus.cmd_strb : '0;
                  bus.cmd_ready <= 1'b0;
                  bus.psel      <= 1'b1;
                  state         <= SETUP;
               end
            end
            SETUP: begin
               bus.penable <= 1'b1;
               wait_cnt    <= '0;
               state       <= ACCESS;
            end
            ACCESS: begin
               if (bus.pready) begin
                  bus.rsp_rdata   <= bus.pwrite ? '0 : bus.prdata;
                  bus.rsp_slverr  <= bus.pslverr;
                  bus.rsp_timeout <= 1'b0;
                  bus.psel        <= 1'b0;
                  bus.penable     <= 1'b0;
                  bus.rsp_valid   <= 1'b1;
                  state           <= RESP;
               end else if (TIMEOUT_EN && (wait_cnt == CNT_LIMIT)) begin
                  bus.rsp_rdata   <= '0;
                  bus.rsp_slverr  <= 1'b1;
                  bus.rsp_timeout <= 1'b1;
                  bus.psel        <= 1'b0;
                  bus.penable     <= 1'b0;
                  bus.rsp_valid   <= 1'b1;
                  state           <= RESP;
               end else if (wait_cnt != CNT_MAX) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.cmd_ready <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: begin
               state         <= IDLE;
               bus.cmd_ready <= 1'b1;
               bus.psel      <= 1'b0;
               bus.penable   <= 1'b0;
               bus.rsp_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_apb4_cmd_master.sv
// Self-checking bench for apb4_cmd_master: a timeline model of each transfer
// (accept edge, ACCESS window, response window) is compared with the DUT on
// every cycle, and directed transfers add hand-computed literal expectations.
module tb_apb4_cmd_master;
   localparam int ADDR_WIDTH = 3;
   localparam int DATA_WIDTH = 32;
   localparam int TIMEOUT    = 16;

   logic pclk;
   logic presetn;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   apb4_cmd_master_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

   apb4_cmd_master #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .pclk(pclk),
      .presetn(presetn),
      .bus(bus)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   // Cycle index: during cycle n exactly n rising edges have occurred.
   always @(posedge pclk) cyc <= cyc + 1;

   // Records one comparison and reports it when the values differ.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
      else
         n_pass++;
   endtask

   // Timeline model of the requester.
   bit          m_live = 1'b0;
   bit          m_busy = 1'b0;
   int          m_acc = 0;
   int          m_end = -1;
   logic [2:0]  m_addr = '0;
   bit          m_write = 1'b0;
   logic [31:0] m_wdata = '0;
   logic [3:0]  m_strb = '0;
   logic [31:0] m_rdata = '0;
   bit          m_err = 1'b0;
   bit          m_to = 1'b0;

   // Compares every output against the model on the falling edge, then advances the model.
   always @(negedge pclk) begin
      bit setup_c;
      bit access_c;
      bit resp_c;
      int k;
      setup_c  = m_busy && (cyc == m_acc);
      access_c = m_busy && (cyc >= m_acc + 1) && (m_end < 0);
      resp_c   = m_busy && (m_end >= 0) && (cyc > m_end);
      if (m_live) begin
         checkOutput("cmd_ready", bus.cmd_ready, !m_busy);
         checkOutput("psel", bus.psel, setup_c || access_c);
         checkOutput("penable", bus.penable, access_c);
         checkOutput("rsp_valid", bus.rsp_valid, resp_c);
         checkOutput("paddr", bus.paddr, m_addr);
         checkOutput("pwrite", bus.pwrite, m_write);
         checkOutput("pwdata", bus.pwdata, m_wdata);
         checkOutput("pstrb", bus.pstrb, m_strb);
         checkOutput("pprot", bus.pprot, 3'b000);
         if (resp_c) begin
            checkOutput("rsp_rdata", bus.rsp_rdata, m_rdata);
            checkOutput("rsp_slverr", bus.rsp_slverr, m_err);
            checkOutput("rsp_timeout", bus.rsp_timeout, m_to);
         end
      end
      if (!presetn) begin
         m_live  = 1'b1;
         m_busy  = 1'b0;
         m_end   = -1;
         m_addr  = '0;
         m_write = 1'b0;
         m_wdata = '0;
         m_strb  = '0;
         m_rdata = '0;
         m_err   = 1'b0;
         m_to    = 1'b0;
      end else if (!m_busy) begin
         if (bus.cmd_valid) begin
            m_busy  = 1'b1;
            m_acc   = cyc + 1;
            m_end   = -1;
            m_addr  = bus.cmd_addr;
            m_write = bus.cmd_write;
            m_wdata = bus.cmd_wdata;
            m_strb  = bus.cmd_write ? bus.cmd_strb : 4'h0;
         end
      end else if (access_c) begin
         k = cyc - (m_acc + 1);
         if (bus.pready) begin
            m_end   = cyc;
            m_rdata = m_write ? 32'h0 : bus.prdata;
            m_err   = bus.pslverr;
            m_to    = 1'b0;
         end else if (TIMEOUT != 0 && k == TIMEOUT) begin
            m_end   = cyc;
            m_rdata = 32'h0;
            m_err   = 1'b1;
            m_to    = 1'b1;
         end
      end else if (resp_c && bus.rsp_ready) begin
         m_busy = 1'b0;
      end
   end

   // Issues one command and plays the slave: pready rises on ACCESS cycle index 'waits'
   // (never if negative). Returns in the first RESP cycle with the ACCESS cycle count.
   task automatic applyStimulus(input bit wr, input logic [2:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input int waits, input logic [31:0] rdata,
                                input bit err, output int acc_cycles);
      int guard;
      acc_cycles = 0;
      guard = 0;
      while (!bus.cmd_ready && guard < 20) begin
         @(posedge pclk); #1;
         guard++;
      end
      if (!bus.cmd_ready) checkOutput("cmd_ready_wait", bus.cmd_ready, 1'b1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      bus.cmd_strb  = strb;
      @(posedge pclk); #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_wdata = 32'h0;
      bus.cmd_strb  = 4'h0;
      checkOutput("setup_psel", bus.psel, 1'b1);
      checkOutput("setup_penable", bus.penable, 1'b0);
      @(posedge pclk); #1;
      for (int k = 0; k < 40; k++) begin
         bus.pready  = (k == waits);
         bus.prdata  = (k == waits) ? rdata : ~rdata;
         bus.pslverr = (k == waits) ? err : !err;
         acc_cycles++;
         @(posedge pclk); #1;
         if (bus.pready) break;
         if (!bus.psel) break;
      end
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = 32'h0;
      checkOutput("rsp_valid_up", bus.rsp_valid, 1'b1);
      checkOutput("psel_down", bus.psel, 1'b0);
   endtask

   // Holds off the response for 'hold' cycles, then consumes it.
   task automatic consumeResponse(input int hold);
      repeat (hold) begin
         checkOutput("bp_cmd_ready", bus.cmd_ready, 1'b0);
         @(posedge pclk); #1;
      end
      bus.rsp_ready = 1'b1;
      @(posedge pclk); #1;
      bus.rsp_ready = 1'b0;
      checkOutput("cmd_ready_after_rsp", bus.cmd_ready, 1'b1);
      checkOutput("rsp_valid_down", bus.rsp_valid, 1'b0);
   endtask

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenario sequence with literal expectations.
   initial begin
      int acc;
      presetn       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.cmd_strb  = '0;
      bus.prdata    = '0;
      bus.pready    = 1'b0;
      bus.pslverr   = 1'b0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(posedge pclk);
      #1;
      checkOutput("reset_psel", bus.psel, 1'b0);
      checkOutput("reset_penable", bus.penable, 1'b0);
      checkOutput("reset_rsp_valid", bus.rsp_valid, 1'b0);
      checkOutput("reset_cmd_ready", bus.cmd_ready, 1'b1);
      checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
      presetn = 1'b1;
      @(posedge pclk); #1;

      $display("[TB] zero-wait write");
      applyStimulus(1'b1, 3'h0, 32'hDEADBEEF, 4'hF, 0, 32'h1111_2222, 1'b0, acc);
      checkOutput("zw_access_cycles", acc, 1);
      checkOutput("zw_rsp_rdata", bus.rsp_rdata, 32'h0);
      checkOutput("zw_rsp_slverr", bus.rsp_slverr, 1'b0);
      checkOutput("zw_pwdata_hold", bus.pwdata, 32'hDEADBEEF);
      consumeResponse(0);

      $display("[TB] read with 3 wait states");
      applyStimulus(1'b0, 3'h2, 32'h0, 4'h0, 3, 32'hCAFEBABE, 1'b0, acc);
      checkOutput("rd_access_cycles", acc, 4);
      checkOutput("rd_rsp_rdata", bus.rsp_rdata, 32'hCAFEBABE);
      checkOutput("rd_paddr", bus.paddr, 3'h2);
      consumeResponse(0);

      $display("[TB] read with slave error");
      applyStimulus(1'b0, 3'h4, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b1, acc);
      checkOutput("err_rsp_slverr", bus.rsp_slverr, 1'b1);
      checkOutput("err_rsp_timeout", bus.rsp_timeout, 1'b0);
      checkOutput("err_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
      consumeResponse(0);

      $display("[TB] partial-strobe write");
      applyStimulus(1'b1, 3'h5, 32'h0BAD_F00D, 4'h5, 1, 32'h0, 1'b0, acc);
      checkOutput("ps_pstrb", bus.pstrb, 4'h5);
      checkOutput("ps_access_cycles", acc, 2);
      consumeResponse(0);

      $display("[TB] timeout");
      applyStimulus(1'b0, 3'h1, 32'h0, 4'h0, -1, 32'h7777_7777, 1'b0, acc);
      checkOutput("to_access_cycles", acc, 17);
      checkOutput("to_rsp_timeout", bus.rsp_timeout, 1'b1);
      checkOutput("to_rsp_slverr", bus.rsp_slverr, 1'b1);
      checkOutput("to_rsp_rdata", bus.rsp_rdata, 32'h0);
      consumeResponse(0);

      $display("[TB] pready on the timeout limit cycle");
      applyStimulus(1'b0, 3'h6, 32'h0, 4'h0, 16, 32'hA5A5_5A5A, 1'b0, acc);
      checkOutput("lim_access_cycles", acc, 17);
      checkOutput("lim_rsp_timeout", bus.rsp_timeout, 1'b0);
      checkOutput("lim_rsp_slverr", bus.rsp_slverr, 1'b0);
      checkOutput("lim_rsp_rdata", bus.rsp_rdata, 32'hA5A5_5A5A);
      consumeResponse(0);

      $display("[TB] response backpressure");
      applyStimulus(1'b1, 3'h7, 32'h0102_0304, 4'h3, 2, 32'h0, 1'b0, acc);
      consumeResponse(5);

      $display("[TB] reset during ACCESS");
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 3'h3;
      @(posedge pclk); #1;
      bus.cmd_valid = 1'b0;
      repeat (4) @(posedge pclk);
      #1;
      checkOutput("mid_penable", bus.penable, 1'b1);
      presetn = 1'b0;
      @(posedge pclk); #1;
      presetn = 1'b1;
      checkOutput("rst_psel", bus.psel, 1'b0);
      checkOutput("rst_penable", bus.penable, 1'b0);
      checkOutput("rst_rsp_valid", bus.rsp_valid, 1'b0);
      checkOutput("rst_cmd_ready", bus.cmd_ready, 1'b1);
      checkOutput("rst_paddr", bus.paddr, 3'h0);
      repeat (5) @(posedge pclk);
      #1;
      checkOutput("rst_no_rsp", bus.rsp_valid, 1'b0);

      $display("[TB] recovery write");
      applyStimulus(1'b1, 3'h2, 32'h5555_AAAA, 4'hC, 0, 32'h0, 1'b0, acc);
      checkOutput("rec_pwdata", bus.pwdata, 32'h5555_AAAA);
      consumeResponse(0);

      repeat (3) @(posedge pclk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/apb4_cmd_master.md
# apb4_cmd_master

APB4 requester that sits directly upstream of `apb4_csr_top` and drives its `Bus2Master_intf` slave port.

- Converts a valid/ready command stream (read or write, address, data, strobes) into compliant APB4 SETUP/ACCESS transfers.
- Waits for `pready` and returns read data and error status on a valid/ready response channel.
- Aborts transfers that stall too long, using a bounded wait-state timeout.

## Interface
Parameters:
- ADDR_WIDTH, 3, APB address width; matches the `apb4_csr_top` address space.
- DATA_WIDTH, 32, APB data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with `pready` low before abort; 0 disables the timeout.

Ports:
- pclk  in  1  sole clock; all logic on rising edge.
- presetn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- psel, penable, pwrite  out  1  APB4 control.
- paddr  out  ADDR_WIDTH  APB4 address.
- pwdata  out  DATA_WIDTH  APB4 write data.
- pstrb  out  DATA_WIDTH/8  APB4 strobes; all zero during reads.
- pprot  out  3  constant 3'b000.
- prdata  in  DATA_WIDTH  APB4 read data.
- pready, pslverr  in  1  APB4 completion and error.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_slverr  out  1  pslverr captured, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch write, addr, wdata and strb into paddr/pwrite/pwdata/pstrb; go to SETUP.
- SETUP: psel=1, penable=0; go to ACCESS unconditionally.
- ACCESS:
  - psel=1, penable=1.
  - Sample pready each cycle.
  - On pready=1:
    - capture rsp_rdata = pwrite ? 0 : prdata;
    - capture rsp_slverr = pslverr; rsp_timeout=0;
    - go to RESP.
- Timeout:
  - Wait counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When TIMEOUT_CYCLES != 0 and counter reaches TIMEOUT_CYCLES with pready still 0: go to RESP with rsp_rdata=0, rsp_slverr=1, rsp_timeout=1.
  - pready=1 in the same cycle the limit is reached wins: normal completion, no timeout.
  - Counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- RESP:
  - psel=0, penable=0, rsp_valid=1.
  - rsp_* fields stay stable until rsp_ready=1, then go to IDLE.
- paddr/pwrite/pwdata/pstrb hold their last values after a transfer until the next command is accepted.
- cmd_ready is 0 in every state except IDLE: one outstanding transfer, no command buffering.
- pslverr and prdata are ignored outside ACCESS cycles where pready=1.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE; cmd_ready=1.
  - psel=0, penable=0, pwrite=0.
  - paddr, pwdata, pstrb = 0; pprot = 0.
  - rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0.
- Command handshake at edge N: SETUP during cycle N+1, ACCESS from N+2.
- Zero-wait slave (pready=1 in first ACCESS cycle): rsp_valid=1 from N+3; psel=0 from N+3.
- Each wait state adds one cycle.
- With rsp_ready held high, throughput is one transfer per 4 cycles: next cmd_ready=1 at N+4.
- paddr, pwrite, pwdata and pstrb are stable from SETUP through the last ACCESS cycle (APB4 rule).
- Timeout with limit T: psel/penable drop and rsp_valid rises T+1 cycles after ACCESS entry.
- presetn=0 sampled at any edge, including mid-ACCESS or RESP:
  - all registers return to reset values next cycle;
  - in-flight transfer and pending response are discarded; no response is issued.

## Test plan
- Reset: hold presetn=0 for 2 edges -> psel=0, penable=0, rsp_valid=0, cmd_ready=1.
- Zero-wait write: addr 3'h0, data 32'hDEADBEEF, strb 4'hF -> one SETUP then one ACCESS cycle with those values; rsp_valid 3 cycles after accept; rsp_rdata=0, rsp_slverr=0.
- Read with 3 wait states, prdata 32'hCAFEBABE -> penable high for 4 cycles; rsp_rdata=32'hCAFEBABE; paddr stable throughout.
- Error: pready=1 with pslverr=1 on a read of 3'h4 -> rsp_slverr=1, rsp_timeout=0; next command accepted after rsp_ready.
- Timeout: TIMEOUT_CYCLES=16, pready held 0 -> abort after 17 ACCESS cycles; rsp_timeout=1, rsp_slverr=1, rsp_rdata=0. Repeat with pready=1 exactly on cycle 16 -> normal completion.
- Backpressure and reset: rsp_ready=0 for 5 cycles -> rsp fields stable, cmd_ready=0. Then assert presetn=0 mid-ACCESS -> psel=0 and rsp_valid=0 next cycle, no response emitted.
